// File: rtl/mod_count_pkg.sv
// Shared definitions for the 5..15 wrap-around counter and its downstream checker.
package mod_count_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_LO    = 5;
  localparam int unsigned CNT_HI    = 15;

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: clear has priority, holds at all-ones.
module sat_counter #(
  parameter int unsigned STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [STAT_W-1:0] q
);

  logic [STAT_W-1:0] r_q;

  // Count register: clear beats increment, increment stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {STAT_W{1'b1}})) begin
      r_q <= r_q + STAT_W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mod_count_checker.sv
// Monitor that checks a LO..HI wrap-around counter sequence, tracks lock,
// flags violations and keeps saturating wrap/error statistics.
module mod_count_checker
  import mod_count_pkg::*;
#(
  parameter int unsigned WIDTH    = CNT_WIDTH,
  parameter int unsigned LO       = CNT_LO,
  parameter int unsigned HI       = CNT_HI,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned STAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              valid_in,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic              fault_seen,
  output logic [STAT_W-1:0] wrap_count,
  output logic [STAT_W-1:0] err_count
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] LO_V   = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V   = WIDTH'(HI);
  localparam logic [WIDTH:0]   LO_EXT = (WIDTH + 1)'(LO);
  localparam logic [WIDTH:0]   HI_EXT = (WIDTH + 1)'(HI);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic             r_wrap_pulse;
  logic             r_fault_seen;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [RUN_W-1:0] w_run_inc;
  logic [WIDTH-1:0] w_exp;
  logic             w_in_range;
  logic             w_match;
  logic             w_err;
  logic             w_wrap;

  // Expected successor of the previous sample and range/match decode.
  // Range compare is done one bit wider so HI may equal the all-ones value.
  assign w_exp      = (r_prev == HI_V) ? LO_V : (r_prev + WIDTH'(1));
  assign w_in_range = ({1'b0, cnt_in} >= LO_EXT) && ({1'b0, cnt_in} <= HI_EXT);
  assign w_match    = (cnt_in == w_exp);
  assign w_run_inc  = r_run + RUN_W'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNSYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; transitions only on qualified samples.
  always_comb begin
    w_state_nxt = r_state;
    if (valid_in) begin
      case (r_state)
        ST_UNSYNC:  if (w_in_range) w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (w_match) begin
            if (w_run_inc == LOCK_V) w_state_nxt = ST_LOCKED;
          end else if (!w_in_range) begin
            w_state_nxt = ST_UNSYNC;
          end
        end
        ST_LOCKED:  if (!w_match) w_state_nxt = ST_FAULT;
        ST_FAULT:   w_state_nxt = w_in_range ? ST_ACQUIRE : ST_UNSYNC;
        default:    w_state_nxt = ST_UNSYNC;
      endcase
    end
  end

  // Per-state datapath updates and event strobes.
  always_comb begin
    w_prev_nxt = r_prev;
    w_run_nxt  = r_run;
    w_err      = 1'b0;
    w_wrap     = 1'b0;
    if (valid_in) begin
      case (r_state)
        ST_UNSYNC: begin
          if (w_in_range) begin
            w_prev_nxt = cnt_in;
            w_run_nxt  = '0;
          end
        end
        ST_ACQUIRE: begin
          w_prev_nxt = cnt_in;
          w_run_nxt  = w_match ? w_run_inc : '0;
        end
        ST_LOCKED: begin
          w_prev_nxt = cnt_in;
          if (w_match) begin
            w_wrap = (r_prev == HI_V);
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_prev_nxt = cnt_in;
          w_run_nxt  = '0;
        end
      endcase
    end
  end

  // Previous-sample and run-length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_run  <= '0;
    end else begin
      r_prev <= w_prev_nxt;
      r_run  <= w_run_nxt;
    end
  end

  // Registered status: lock level, one-cycle strobes and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_fault_seen <= 1'b0;
    end else begin
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_err_pulse  <= w_err;
      r_wrap_pulse <= w_wrap;
      if (clr) begin
        r_fault_seen <= 1'b0;
      end else if (w_err) begin
        r_fault_seen <= 1'b1;
      end
    end
  end

  sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_wrap),
    .clr (clr),
    .q   (wrap_count)
  );

  sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_err),
    .clr (clr),
    .q   (err_count)
  );

  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign fault_seen = r_fault_seen;

endmodule

// File: tb/tb_mod_count_checker.sv
// Directed bench for mod_count_checker with hand-computed expectations.
module tb_mod_count_checker;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       valid_in;
  logic       clr;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic       fault_seen;
  logic [7:0] wrap_count;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_mis = 0;

  mod_count_checker #(
    .WIDTH(4), .LO(5), .HI(15), .LOCK_CNT(2), .STAT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .valid_in   (valid_in),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .fault_seen (fault_seen),
    .wrap_count (wrap_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [3:0] c, input logic cl);
    cnt_in   = c;
    valid_in = v;
    clr      = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},     32'(locked),     32'd0);
    chk({tag, "_err_pulse"},  32'(err_pulse),  32'd0);
    chk({tag, "_wrap_pulse"}, 32'(wrap_pulse), 32'd0);
    chk({tag, "_fault_seen"}, 32'(fault_seen), 32'd0);
    chk({tag, "_wrap_count"}, 32'(wrap_count), 32'd0);
    chk({tag, "_err_count"},  32'(err_count),  32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step(1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b0);
  endtask

  logic [7:0] snap_wrap;
  logic [7:0] snap_err;

  initial begin
    rst      = 1'b1;
    cnt_in   = '0;
    valid_in = 1'b0;
    clr      = 1'b0;

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // 1: 5,6,7 -> locked after the 7 sample
    step(1'b1, 4'd5, 1'b0);
    chk("t1_after5_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd6, 1'b0);
    chk("t1_after6_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd7, 1'b0);
    chk("t1_after7_locked", 32'(locked), 32'd1);
    chk("t1_err_count", 32'(err_count), 32'd0);

    // 2: run up to 14,15,5 -> one wrap pulse after the 5 sample
    for (int v = 8; v <= 14; v++) step(1'b1, 4'(v), 1'b0);
    step(1'b1, 4'd15, 1'b0);
    chk("t2_after15_wrap_pulse", 32'(wrap_pulse), 32'd0);
    step(1'b1, 4'd5, 1'b0);
    chk("t2_after5_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t2_wrap_count", 32'(wrap_count), 32'd1);
    chk("t2_locked", 32'(locked), 32'd1);
    step(1'b1, 4'd6, 1'b0);
    chk("t2_after6_wrap_pulse", 32'(wrap_pulse), 32'd0);
    chk("t2_wrap_count_hold", 32'(wrap_count), 32'd1);

    // 3: locked at 9, upstream reset to 5 is a violation
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    chk("t3_locked_at9", 32'(locked), 32'd1);
    step(1'b1, 4'd5, 1'b0);
    chk("t3_err_pulse", 32'(err_pulse), 32'd1);
    chk("t3_err_count", 32'(err_count), 32'd1);
    chk("t3_fault_seen", 32'(fault_seen), 32'd1);
    chk("t3_locked_drop", 32'(locked), 32'd0);
    // FAULT consumes 6 into ACQUIRE; 7 and 8 are the two correct transitions.
    step(1'b1, 4'd6, 1'b0);
    chk("t3_after6_err_pulse", 32'(err_pulse), 32'd0);
    chk("t3_after6_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd7, 1'b0);
    chk("t3_after7_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd8, 1'b0);
    chk("t3_relock", 32'(locked), 32'd1);
    chk("t3_fault_sticky", 32'(fault_seen), 32'd1);
    chk("t3_err_count_hold", 32'(err_count), 32'd1);

    // 4: out-of-range samples in UNSYNC are ignored
    do_reset();
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    chk("t4_oor_locked", 32'(locked), 32'd0);
    chk("t4_oor_err_count", 32'(err_count), 32'd0);
    chk("t4_oor_fault", 32'(fault_seen), 32'd0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    chk("t4_after9_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd10, 1'b0);
    chk("t4_after10_locked", 32'(locked), 32'd1);

    // 5: invalid cycles with garbage do nothing
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'((i * 7 + 3) % 16), 1'b0);
      chk("t5_idle_pulses", 32'({err_pulse, wrap_pulse}), 32'd0);
    end
    chk("t5_idle_locked", 32'(locked), 32'd1);
    chk("t5_idle_err_count", 32'(err_count), 32'd0);
    // prev must still be 10: continue with 11..15,5
    for (int v = 11; v <= 15; v++) step(1'b1, 4'(v), 1'b0);
    step(1'b1, 4'd5, 1'b0);
    chk("t5_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t5_wrap_count", 32'(wrap_count), 32'd1);
    chk("t5_no_err", 32'(err_count), 32'd0);
    for (int v = 6; v <= 15; v++) step(1'b1, 4'(v), 1'b0);
    step(1'b1, 4'd5, 1'b1);
    chk("t5_clr_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t5_clr_wrap_count", 32'(wrap_count), 32'd0);
    chk("t5_clr_locked", 32'(locked), 32'd1);

    // 6: 300 wraps saturate wrap_count at 255
    for (int w = 0; w < 300; w++) begin
      for (int v = 6; v <= 15; v++) step(1'b1, 4'(v), 1'b0);
      step(1'b1, 4'd5, 1'b0);
    end
    chk("t6_wrap_sat", 32'(wrap_count), 32'd255);
    chk("t6_wrap_pulse_at_sat", 32'(wrap_pulse), 32'd1);
    chk("t6_err_count", 32'(err_count), 32'd0);
    chk("t6_locked", 32'(locked), 32'd1);
    snap_wrap = wrap_count;
    snap_err  = err_count;
    step(1'b1, 4'd6, 1'b0);
    chk("t6_wrap_hold", 32'(wrap_count), 32'(snap_wrap));
    chk("t6_err_hold", 32'(err_count), 32'(snap_err));

    // Mid-run async reset drops the pending pulse
    for (int v = 7; v <= 15; v++) step(1'b1, 4'(v), 1'b0);
    step(1'b1, 4'd5, 1'b0);
    chk("t6_pre_rst_pulse", 32'(wrap_pulse), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_async_rst");
    step(1'b1, 4'd6, 1'b0);
    rst = 1'b0;
    // FSM back in UNSYNC: 7 enters ACQUIRE, 8 counts one, 9 locks
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    chk("t6_unsync_after8", 32'(locked), 32'd0);
    step(1'b1, 4'd9, 1'b0);
    chk("t6_unsync_after9", 32'(locked), 32'd1);
    chk("t6_post_rst_wrap_count", 32'(wrap_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
